// File: rtl/scr1_tcm_sp_pkg.sv
// Shared memory-interface definitions for the single-port TCM: response/command
// codes, access width enum and byte-lane helpers.
package scr1_tcm_sp_pkg;

    localparam int SCR1_IMEM_AWIDTH = 32;
    localparam int SCR1_IMEM_DWIDTH = 32;
    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    function automatic logic [3:0] scr1_byte_en(input type_scr1_mem_width_e width,
                                                 input logic [1:0] addr_lo);
        case (width)
            SCR1_MEM_WIDTH_BYTE:  return 4'b0001 << addr_lo;
            SCR1_MEM_WIDTH_HWORD: return 4'b0011 << {addr_lo[1], 1'b0};
            default:              return 4'b1111;
        endcase
    endfunction

    // LSB-aligned write data copied onto every lane the enable may select
    function automatic logic [31:0] scr1_wdata_lanes(input type_scr1_mem_width_e width,
                                                     input logic [31:0] wdata);
        case (width)
            SCR1_MEM_WIDTH_BYTE:  return {4{wdata[7:0]}};
            SCR1_MEM_WIDTH_HWORD: return {2{wdata[15:0]}};
            default:              return wdata;
        endcase
    endfunction

endpackage

// File: rtl/scr1_tcm_sp_mem.sv
// Single-port 32-bit word array with byte write enables and a registered read port.
module scr1_sp_memory #(
    parameter int SIZE = 32'h00004000
) (
    input  logic                      clk,
    input  logic                      i_re,
    input  logic [3:0]                i_we,
    input  logic [$clog2(SIZE)-3:0]   i_idx,
    input  logic [31:0]               i_wdata,
    output logic [31:0]               o_rdata
);

    logic [31:0] r_mem [SIZE/4];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/scr1_tcm_sp.sv
// Tightly coupled memory shared by the instruction and data ports: round-robin
// arbitration, one transaction in flight, programmable wait states.
module scr1_tcm_sp
    import scr1_tcm_sp_pkg::*;
#(
    parameter logic [31:0] SCR1_TCM_SIZE = 32'h00004000,
    parameter int          SCR1_TCM_WS   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          imem_req,
    output logic                          imem_req_ack,
    input  logic [SCR1_IMEM_AWIDTH-1:0]   imem_addr,
    output logic [SCR1_IMEM_DWIDTH-1:0]   imem_rdata,
    output type_scr1_mem_resp_e           imem_resp,
    input  logic                          dmem_req,
    output logic                          dmem_req_ack,
    input  type_scr1_mem_cmd_e            dmem_cmd,
    input  type_scr1_mem_width_e          dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata,
    output logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata,
    output type_scr1_mem_resp_e           dmem_resp
);

    localparam int         MEM_AW  = $clog2(SCR1_TCM_SIZE);
    localparam int         CNT_W   = $clog2(4);
    localparam logic [CNT_W-1:0] WS_LOAD = (SCR1_TCM_WS == 0) ? '0 : CNT_W'(SCR1_TCM_WS - 1);

    typedef enum logic [1:0] {
        TCM_IDLE,
        TCM_WAIT,
        TCM_RESP
    } type_tcm_fsm_e;

    type_tcm_fsm_e       r_state, w_state_next;
    logic [CNT_W-1:0]    r_ws_cnt, w_ws_cnt_next;
    logic                r_ready;
    logic                r_port_dmem;
    logic                r_err;
    logic                r_rd;
    logic [1:0]          r_byte_sh;
    logic [31:0]         r_imem_rdata, r_dmem_rdata;

    logic                w_can_acc, w_gnt_dmem, w_gnt_imem, w_acc;
    logic                w_imem_err, w_dmem_err, w_err;
    logic                w_mem_re;
    logic [3:0]          w_mem_we;
    logic [MEM_AW-3:0]   w_mem_idx;
    logic [31:0]         w_mem_wdata, w_mem_rdata, w_dmem_rdata_sh;
    logic                w_resp_now, w_imem_rd_ok, w_dmem_rd_ok;
    type_scr1_mem_resp_e w_resp_code;

    // r_port_dmem doubles as the round-robin pointer: the port granted last
    assign w_can_acc    = r_ready & (r_state != TCM_WAIT);
    assign w_gnt_dmem   = dmem_req & (~imem_req | ~r_port_dmem);
    assign w_gnt_imem   = imem_req & ~w_gnt_dmem;
    assign imem_req_ack = w_can_acc & w_gnt_imem;
    assign dmem_req_ack = w_can_acc & w_gnt_dmem;
    assign w_acc        = imem_req_ack | dmem_req_ack;

    assign w_imem_err = (imem_addr[1:0] != 2'b00) | (imem_addr >= SCR1_TCM_SIZE);

    always_comb begin
        w_dmem_err = (dmem_addr >= SCR1_TCM_SIZE);
        case (dmem_width)
            SCR1_MEM_WIDTH_BYTE:  ;
            SCR1_MEM_WIDTH_HWORD: if (dmem_addr[0]) w_dmem_err = 1'b1;
            SCR1_MEM_WIDTH_WORD:  if (dmem_addr[1:0] != 2'b00) w_dmem_err = 1'b1;
            default:              w_dmem_err = 1'b1;
        endcase
    end

    assign w_err       = imem_req_ack ? w_imem_err : w_dmem_err;
    assign w_mem_idx   = imem_req_ack ? imem_addr[MEM_AW-1:2] : dmem_addr[MEM_AW-1:2];
    assign w_mem_re    = w_acc & ~w_err & (imem_req_ack | (dmem_cmd == SCR1_MEM_CMD_RD));
    assign w_mem_we    = (dmem_req_ack & ~w_dmem_err & (dmem_cmd == SCR1_MEM_CMD_WR))
                         ? scr1_byte_en(dmem_width, dmem_addr[1:0]) : 4'b0000;
    assign w_mem_wdata = scr1_wdata_lanes(dmem_width, dmem_wdata);

    scr1_sp_memory #(
        .SIZE    (SCR1_TCM_SIZE)
    ) u_mem (
        .clk     (clk),
        .i_re    (w_mem_re),
        .i_we    (w_mem_we),
        .i_idx   (w_mem_idx),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= TCM_IDLE;
            r_ws_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_ws_cnt <= w_ws_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_ws_cnt_next = r_ws_cnt;
        case (r_state)
            TCM_IDLE, TCM_RESP: begin
                if (w_acc) begin
                    if (SCR1_TCM_WS == 0) begin
                        w_state_next = TCM_RESP;
                    end else begin
                        w_state_next  = TCM_WAIT;
                        w_ws_cnt_next = WS_LOAD;
                    end
                end else begin
                    w_state_next = TCM_IDLE;
                end
            end
            TCM_WAIT: begin
                if (r_ws_cnt == '0) begin
                    w_state_next = TCM_RESP;
                end else begin
                    w_ws_cnt_next = r_ws_cnt - 1'b1;
                end
            end
            default: w_state_next = TCM_IDLE;
        endcase
    end

    // r_ready keeps both acks low for the first cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready     <= 1'b0;
            r_port_dmem <= 1'b0;
            r_err       <= 1'b0;
            r_rd        <= 1'b0;
            r_byte_sh   <= 2'b00;
        end else begin
            r_ready <= 1'b1;
            if (w_acc) begin
                r_port_dmem <= dmem_req_ack;
                r_err       <= w_err;
                r_rd        <= imem_req_ack | (dmem_cmd == SCR1_MEM_CMD_RD);
                r_byte_sh   <= dmem_addr[1:0];
            end
        end
    end

    assign w_resp_now      = (r_state == TCM_RESP);
    assign w_imem_rd_ok    = w_resp_now & ~r_port_dmem & ~r_err;
    assign w_dmem_rd_ok    = w_resp_now & r_port_dmem & r_rd & ~r_err;
    assign w_dmem_rdata_sh = w_mem_rdata >> {r_byte_sh, 3'b000};

    // Read data is forwarded during RESP and latched so it survives later reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imem_rdata <= '0;
            r_dmem_rdata <= '0;
        end else begin
            if (w_imem_rd_ok) r_imem_rdata <= w_mem_rdata;
            if (w_dmem_rd_ok) r_dmem_rdata <= w_dmem_rdata_sh;
        end
    end

    assign imem_rdata  = w_imem_rd_ok ? w_mem_rdata : r_imem_rdata;
    assign dmem_rdata  = w_dmem_rd_ok ? w_dmem_rdata_sh : r_dmem_rdata;
    assign w_resp_code = r_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    assign imem_resp   = (w_resp_now & ~r_port_dmem) ? w_resp_code : SCR1_MEM_RESP_NOTRDY;
    assign dmem_resp   = (w_resp_now &  r_port_dmem) ? w_resp_code : SCR1_MEM_RESP_NOTRDY;

endmodule

// File: tb/tb_scr1_tcm_sp.sv
// Bench for scr1_tcm_sp: four instances (0..3 wait states) share one stimulus
// stream; each is checked every cycle against a transaction-level model.
module tb_scr1_tcm_sp;
    import scr1_tcm_sp_pkg::*;

    localparam int TB_SIZE = 16384;

    bit                   clk;
    logic                 rst_n = 1'b1;
    logic                 imem_req = 1'b0;
    logic [31:0]          imem_addr = '0;
    logic                 dmem_req = 1'b0;
    type_scr1_mem_cmd_e   dmem_cmd = SCR1_MEM_CMD_RD;
    type_scr1_mem_width_e dmem_width = SCR1_MEM_WIDTH_WORD;
    logic [31:0]          dmem_addr = '0;
    logic [31:0]          dmem_wdata = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int WS = g;

        logic                ia, da;
        type_scr1_mem_resp_e ir, dr;
        logic [31:0]         ird, drd;

        scr1_tcm_sp #(
            .SCR1_TCM_SIZE (32'(TB_SIZE)),
            .SCR1_TCM_WS   (WS)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .imem_req     (imem_req),
            .imem_req_ack (ia),
            .imem_addr    (imem_addr),
            .imem_rdata   (ird),
            .imem_resp    (ir),
            .dmem_req     (dmem_req),
            .dmem_req_ack (da),
            .dmem_cmd     (dmem_cmd),
            .dmem_width   (dmem_width),
            .dmem_addr    (dmem_addr),
            .dmem_wdata   (dmem_wdata),
            .dmem_rdata   (drd),
            .dmem_resp    (dr)
        );

        // Byte-level memory image; kb marks bytes whose content is known
        logic [7:0]  mb [TB_SIZE];
        bit          kb [TB_SIZE];
        int          cyc = 0, up = 0, p_due = 0, nb = 0;
        bit          pend = 0, p_dmem = 0, p_err = 0, p_rd = 0, last_dmem = 0;
        bit          resp_now, can, gi, gd;
        logic [31:0] p_data = '0, p_mask = '0;
        logic [31:0] h_i = '0, hm_i = '1, h_d = '0, hm_d = '1;
        logic [31:0] a, w, m;
        type_scr1_mem_resp_e e_ir, e_dr, code;

        function automatic void rd_word(input logic [31:0] base, output logic [31:0] d,
                                        output logic [31:0] msk);
            for (int k = 0; k < 4; k++) begin
                d[8*k +: 8]   = mb[base + k];
                msk[8*k +: 8] = kb[base + k] ? 8'hFF : 8'h00;
            end
        endfunction

        always @(negedge clk) begin
            if (!rst_n) begin
                check_val($sformatf("ws%0d rst imem_ack", WS), 32'(ia), 32'd0);
                check_val($sformatf("ws%0d rst dmem_ack", WS), 32'(da), 32'd0);
                check_val($sformatf("ws%0d rst imem_resp", WS), 32'(ir), 32'(SCR1_MEM_RESP_NOTRDY));
                check_val($sformatf("ws%0d rst dmem_resp", WS), 32'(dr), 32'(SCR1_MEM_RESP_NOTRDY));
                check_val($sformatf("ws%0d rst imem_rdata", WS), ird, 32'd0);
                check_val($sformatf("ws%0d rst dmem_rdata", WS), drd, 32'd0);
                pend = 0; last_dmem = 0; up = 0;
                h_i = '0; hm_i = '1; h_d = '0; hm_d = '1;
            end else begin
                resp_now = pend && (p_due == cyc);
                e_ir = SCR1_MEM_RESP_NOTRDY;
                e_dr = SCR1_MEM_RESP_NOTRDY;
                if (resp_now) begin
                    code = p_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                    if (p_dmem) begin
                        e_dr = code;
                        if (p_rd) begin
                            if (p_err) hm_d = '0;
                            else begin h_d = p_data; hm_d = p_mask; end
                        end
                    end else begin
                        e_ir = code;
                        if (p_err) hm_i = '0;
                        else begin h_i = p_data; hm_i = p_mask; end
                    end
                    pend = 0;
                end
                check_val($sformatf("ws%0d imem_resp", WS), 32'(ir), 32'(e_ir));
                check_val($sformatf("ws%0d dmem_resp", WS), 32'(dr), 32'(e_dr));
                if (hm_i != 0) check_val($sformatf("ws%0d imem_rdata", WS), ird & hm_i, h_i & hm_i);
                if (hm_d != 0) check_val($sformatf("ws%0d dmem_rdata", WS), drd & hm_d, h_d & hm_d);

                // Grant: lone requester wins; on conflict the port not served last
                can = (up >= 1) && !pend;
                if (imem_req && dmem_req) begin
                    gi = last_dmem;
                    gd = !last_dmem;
                end else begin
                    gi = imem_req;
                    gd = dmem_req;
                end
                check_val($sformatf("ws%0d imem_ack", WS), 32'(ia), 32'(can && gi));
                check_val($sformatf("ws%0d dmem_ack", WS), 32'(da), 32'(can && gd));

                if (can && gi) begin
                    a = imem_addr;
                    p_dmem = 0; p_rd = 1;
                    p_err = (a[1:0] != 2'b00) || (a >= TB_SIZE);
                    if (!p_err) rd_word(a, p_data, p_mask);
                end
                if (can && gd) begin
                    a = dmem_addr;
                    p_dmem = 1;
                    p_rd = (dmem_cmd == SCR1_MEM_CMD_RD);
                    p_err = (a >= TB_SIZE)
                         || (dmem_width == SCR1_MEM_WIDTH_HWORD && a[0])
                         || (dmem_width == SCR1_MEM_WIDTH_WORD && a[1:0] != 2'b00);
                    nb = (dmem_width == SCR1_MEM_WIDTH_BYTE) ? 1 :
                         (dmem_width == SCR1_MEM_WIDTH_HWORD) ? 2 : 4;
                    if (!p_err && !p_rd) begin
                        for (int k = 0; k < nb; k++) begin
                            mb[a + k] = dmem_wdata[8*k +: 8];
                            kb[a + k] = 1'b1;
                        end
                    end else if (!p_err) begin
                        rd_word(a & ~32'd3, w, m);
                        p_data = w >> (8 * a[1:0]);
                        p_mask = (m >> (8 * a[1:0])) | ~(32'hFFFF_FFFF >> (8 * a[1:0]));
                    end
                end
                if ((can && gi) || (can && gd)) begin
                    pend = 1;
                    p_due = cyc + WS + 1;
                    last_dmem = can && gd;
                end
                up++;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_op(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e wd,
                        input logic [31:0] ad, input logic [31:0] d);
        dmem_req = 1'b1; dmem_cmd = c; dmem_width = wd; dmem_addr = ad; dmem_wdata = d;
        tick();
        dmem_req = 1'b0;
        repeat (5) tick();
    endtask

    task automatic i_op(input logic [31:0] ad);
        imem_req = 1'b1; imem_addr = ad;
        tick();
        imem_req = 1'b0;
        repeat (5) tick();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 15))
            0:       return 32'h4000 + $urandom_range(0, 63);
            1:       return 32'h3FFC + $urandom_range(0, 3);
            default: return 32'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Directed transactions, each issued to idle instances
        d_op(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h100, 32'h1234_5678);
        i_op(32'h100);
        d_op(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h200, 32'h0);
        d_op(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'h203, 32'h0000_00AB);
        d_op(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h200, 32'h0);
        d_op(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h4000, 32'h0);
        d_op(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h10, 32'hCAFE_F00D);
        d_op(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h11, 32'h5555);
        d_op(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h11, 32'h0);
        d_op(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h10, 32'h0);
        i_op(32'h102);
        d_op(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h203, 32'h0);
        d_op(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h202, 32'h1234);
        d_op(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h202, 32'h0);

        // Both ports requesting continuously straight out of reset
        imem_req = 1'b1; imem_addr = 32'h100;
        dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD;
        dmem_addr = 32'h200;
        do_reset(2);
        repeat (24) tick();
        imem_req = 1'b0;
        repeat (16) tick();
        dmem_req = 1'b0;
        repeat (5) tick();

        // Reset in the middle of a read, then a clean read
        dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD;
        dmem_addr = 32'h10;
        tick();
        dmem_req = 1'b0;
        tick();
        do_reset(1);
        repeat (2) tick();
        d_op(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);

        // A write survives a reset that arrives right after its accept
        dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_WR; dmem_width = SCR1_MEM_WIDTH_WORD;
        dmem_addr = 32'h20; dmem_wdata = 32'h0000_0777;
        tick();
        dmem_req = 1'b0;
        do_reset(1);
        repeat (2) tick();
        d_op(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h20, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            imem_req   = ($urandom_range(0, 9) < 6);
            imem_addr  = ($urandom_range(0, 3) == 0) ? rand_addr() : (rand_addr() & ~32'd3);
            dmem_req   = ($urandom_range(0, 9) < 6);
            dmem_cmd   = type_scr1_mem_cmd_e'($urandom_range(0, 1));
            dmem_width = type_scr1_mem_width_e'($urandom_range(0, 2));
            dmem_addr  = rand_addr();
            dmem_wdata = $urandom();
            rst_n      = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scr1_tcm_sp.md
SCR1_TCM_SP -- requirements
Module: scr1_tcm_sp

Interface
REQ-001 Parameter SCR1_TCM_SIZE, default 32'h00004000: TCM capacity in bytes; power of two, 1 KiB..64 KiB.
REQ-002 Parameter SCR1_TCM_WS, default 1: extra read/write wait states, legal range 0..3.
REQ-003 clk  input  1  single clock for all state; all sequential logic on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  input  1  instruction request.
REQ-006 imem_req_ack  output  1  instruction request accepted this cycle.
REQ-007 imem_addr  input  SCR1_IMEM_AWIDTH  instruction byte address.
REQ-008 imem_rdata  output  SCR1_IMEM_DWIDTH  instruction read data.
REQ-009 imem_resp  output  2  NOTRDY/RDY_OK/RDY_ER response code.
REQ-010 dmem_req  input  1  data request.
REQ-011 dmem_req_ack  output  1  data request accepted this cycle.
REQ-012 dmem_cmd  input  1  SCR1_MEM_CMD_RD / SCR1_MEM_CMD_WR.
REQ-013 dmem_width  input  type_scr1_mem_width_e  BYTE/HWORD/WORD.
REQ-014 dmem_addr  input  SCR1_DMEM_AWIDTH  data byte address.
REQ-015 dmem_wdata  input  SCR1_DMEM_DWIDTH  write data, LSB-aligned.
REQ-016 dmem_rdata  output  SCR1_DMEM_DWIDTH  read data, right-shifted by 8*addr[1:0].
REQ-017 dmem_resp  output  2  response code.

Function
REQ-018 One single-port 32-bit array shared by both ports; at most one transaction in flight.
REQ-019 FSM states IDLE, WAIT, RESP; acceptance allowed only in IDLE or RESP (back-to-back).
REQ-020 Acceptance: req high and req_ack high at a rising edge; accept cycle = T.
REQ-021 Grant: single requester wins; both requesting -> round-robin, port not granted last wins; other req_ack 0.
REQ-022 req_ack of a port SHALL be 0 in WAIT, and 0 when the other port wins arbitration.
REQ-023 Accept with SCR1_TCM_WS=0 -> RESP at T+1; else WAIT for SCR1_TCM_WS cycles, then RESP.
REQ-024 RESP lasts exactly one cycle; only granted port's resp leaves NOTRDY; then IDLE, or re-enter WAIT/RESP if a new accept occurs in that cycle.
REQ-025 Write commits into memory at accept edge with byte enables: BYTE 4'b0001<<addr[1:0], HWORD 4'b0011<<{addr[1],0}, WORD 4'b1111; data replicated as in byte/halfword lanes.
REQ-026 Read issued at accept edge; data captured and held stable from RESP until the next accepted read on that port.
REQ-027 Error: addr >= SCR1_TCM_SIZE, HWORD with addr[0]=1, or WORD with addr[1:0]!=0 -> no array access, resp RDY_ER at the normal response cycle.
REQ-028 imem access always treated as WORD read; imem_addr[1:0]!=0 -> RDY_ER.
REQ-029 Request deassertion after acceptance SHALL NOT cancel the transaction.
REQ-030 Throughput: one transaction per SCR1_TCM_WS+1 cycles under continuous requests.

Reset
REQ-031 rst_n low: FSM IDLE, imem_resp/dmem_resp NOTRDY, req_ack outputs 0, round-robin pointer = imem-last (dmem wins first conflict), rdata outputs 0.
REQ-032 Reset asserted mid-transaction aborts it; no response is produced; a write already committed at its accept edge remains in the array.
REQ-033 req_ack SHALL be 0 in the first cycle after rst_n deassertion, 1 (subject to arbitration) thereafter.

Structure
REQ-034 Response codes, command codes, width enum reused from shared memory-interface package; FSM state enum local.
REQ-035 Array in one sub-module scr1_sp_memory (SIZE, byte write enables, registered read, no reset).
REQ-036 Wait-state counter width $clog2(4); unused when SCR1_TCM_WS=0.

Verification
REQ-037 WS=1, imem_req at 0x100 holding 0x12345678 -> imem_req_ack=1 at T, imem_resp RDY_OK at T+2, rdata 0x12345678.
REQ-038 WS=0, dmem BYTE write 0xAB to 0x203 then WORD read 0x200 (prior 0) -> rdata 0xAB000000, each resp one cycle after accept.
REQ-039 Both ports request continuously from reset -> grants alternate dmem, imem, dmem...; losing req_ack=0.
REQ-040 dmem WORD read at 0x4000 (SIZE 16 KiB) and HWORD at 0x11 -> RDY_ER, memory unchanged.
REQ-041 WS=3, rst_n pulsed low at T+2 of a read -> no response, FSM IDLE, next read completes normally at T'+4.
REQ-042 WS=2, dmem back-to-back reads -> accepts every third cycle, resp in accept cycles after the first.
